// File: rtl/osc_freq_counter_if.sv
// Control/result bundle for osc_freq_counter: start/abort/window in,
// busy/done/count/overflow out. Widths must match the counter instance.
interface osc_freq_counter_if #(
   parameter int unsigned CNT_W = 16,
   parameter int unsigned WIN_W = 16
);
   logic             start;
   logic             abort;
   logic [WIN_W-1:0] window;
   logic             busy;
   logic             done;
   logic [CNT_W-1:0] count;
   logic             overflow;

   modport master (
      output start, abort, window,
      input  busy, done, count, overflow
   );

   modport slave (
      input  start, abort, window,
      output busy, done, count, overflow
   );
endinterface

// File: rtl/osc_freq_counter.sv
// Ring-oscillator frequency counter: enables the oscillator, waits SETTLE
// clk cycles, then counts synchronised rising edges of osc_in over a
// window of clk cycles and publishes the (saturating) count with a
// one-cycle done strobe.
module osc_freq_counter #(
   parameter int unsigned CNT_W  = 16,
   parameter int unsigned WIN_W  = 16,
   parameter int unsigned SETTLE = 16
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                osc_in,
   output logic                osc_en,
   osc_freq_counter_if.slave   bus
);

   // One cycle counter serves both the settle and the measure phases.
   localparam int unsigned SW = $clog2(SETTLE + 1);
   localparam int unsigned CW = (WIN_W > SW) ? WIN_W : SW;

   typedef enum logic [1:0] {
      S_IDLE,
      S_SETTLE,
      S_MEASURE,
      S_DONE
   } state_e;

   state_e           state_q,    state_d;
   logic [WIN_W-1:0] win_q,      win_d;
   logic [CW-1:0]    cyc_q,      cyc_d;
   logic [CNT_W-1:0] edge_cnt_q, edge_cnt_d;
   logic             sat_q,      sat_d;
   logic             sync1_q,    sync1_d;
   logic             sync2_q,    sync2_d;
   logic             sync3_q,    sync3_d;
   logic             osc_en_q,   osc_en_d;
   logic             busy_q,     busy_d;
   logic             done_q,     done_d;
   logic [CNT_W-1:0] count_q,    count_d;
   logic             overflow_q, overflow_d;
   logic             rise;

   assign rise         = sync2_q & ~sync3_q;
   assign osc_en       = osc_en_q;
   assign bus.busy     = busy_q;
   assign bus.done     = done_q;
   assign bus.count    = count_q;
   assign bus.overflow = overflow_q;

   // Next-state logic for the synchroniser, phase sequencer and result registers.
   always_comb begin
      state_d    = state_q;
      win_d      = win_q;
      cyc_d      = cyc_q;
      edge_cnt_d = edge_cnt_q;
      sat_d      = sat_q;
      osc_en_d   = osc_en_q;
      busy_d     = busy_q;
      done_d     = 1'b0;
      count_d    = count_q;
      overflow_d = overflow_q;
      sync1_d    = osc_in;
      sync2_d    = sync1_q;
      sync3_d    = sync2_q;

      case (state_q)
         S_IDLE: begin
            if (bus.start && !bus.abort) begin
               busy_d     = 1'b1;
               cyc_d      = '0;
               edge_cnt_d = '0;
               sat_d      = 1'b0;
               if (bus.window != '0) begin
                  win_d    = bus.window;
                  osc_en_d = 1'b1;
                  state_d  = S_SETTLE;
               end else begin
                  state_d  = S_DONE;
               end
            end
         end
         S_SETTLE: begin
            edge_cnt_d = '0;
            sat_d      = 1'b0;
            if (bus.abort) begin
               osc_en_d = 1'b0;
               busy_d   = 1'b0;
               state_d  = S_IDLE;
            end else if (cyc_q == CW'(SETTLE - 1)) begin
               cyc_d   = '0;
               state_d = S_MEASURE;
            end else begin
               cyc_d = cyc_q + 1'b1;
            end
         end
         S_MEASURE: begin
            if (bus.abort) begin
               osc_en_d = 1'b0;
               busy_d   = 1'b0;
               state_d  = S_IDLE;
            end else begin
               if (rise) begin
                  if (edge_cnt_q == '1) begin
                     sat_d = 1'b1;
                  end else begin
                     edge_cnt_d = edge_cnt_q + 1'b1;
                  end
               end
               if (cyc_q == CW'(win_q) - CW'(1)) begin
                  state_d = S_DONE;
               end else begin
                  cyc_d = cyc_q + 1'b1;
               end
            end
         end
         S_DONE: begin
            done_d     = 1'b1;
            count_d    = edge_cnt_q;
            overflow_d = sat_q;
            osc_en_d   = 1'b0;
            busy_d     = 1'b0;
            state_d    = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // State and registered outputs; reset clears everything asynchronously.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= S_IDLE;
         win_q      <= '0;
         cyc_q      <= '0;
         edge_cnt_q <= '0;
         sat_q      <= 1'b0;
         sync1_q    <= 1'b0;
         sync2_q    <= 1'b0;
         sync3_q    <= 1'b0;
         osc_en_q   <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         count_q    <= '0;
         overflow_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         win_q      <= win_d;
         cyc_q      <= cyc_d;
         edge_cnt_q <= edge_cnt_d;
         sat_q      <= sat_d;
         sync1_q    <= sync1_d;
         sync2_q    <= sync2_d;
         sync3_q    <= sync3_d;
         osc_en_q   <= osc_en_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         count_q    <= count_d;
         overflow_q <= overflow_d;
      end
   end

endmodule

// File: tb/tb_osc_freq_counter.sv
// Directed bench for osc_freq_counter: a 16-bit instance (A) and a 4-bit
// count instance (B) share one oscillator model with programmable period.
module tb_osc_freq_counter;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        osc_in = 1'b0;
   logic        osc_en_a;
   logic        osc_en_b;
   int unsigned osc_half = 5;
   int          passed = 0;
   int          total = 0;

   osc_freq_counter_if #(.CNT_W(16), .WIN_W(16)) bus_a ();
   osc_freq_counter_if #(.CNT_W(4),  .WIN_W(16)) bus_b ();

   osc_freq_counter #(.CNT_W(16), .WIN_W(16), .SETTLE(16)) dut_a (
      .clk    (clk),
      .rst_n  (rst_n),
      .osc_in (osc_in),
      .osc_en (osc_en_a),
      .bus    (bus_a)
   );

   osc_freq_counter #(.CNT_W(4), .WIN_W(16), .SETTLE(16)) dut_b (
      .clk    (clk),
      .rst_n  (rst_n),
      .osc_in (osc_in),
      .osc_en (osc_en_b),
      .bus    (bus_b)
   );

   initial forever #5 clk = ~clk;

   // Oscillator: toggles every osc_half clk periods, 3 time units off the clk grid.
   initial begin
      #3;
      forever begin
         if (osc_half == 0) #10;
         else begin
            #(osc_half * 10);
            osc_in = ~osc_in;
         end
      end
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1, "watchdog");
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic start_a(input logic [15:0] w);
      bus_a.start  = 1'b1;
      bus_a.window = w;
      step();
      bus_a.start  = 1'b0;
   endtask

   // Observes instance A for n samples starting at the current one.
   task automatic run_a(input int n, output int done_j, output int donecnt, output int encnt);
      done_j = -1; donecnt = 0; encnt = 0;
      for (int j = 0; j < n; j++) begin
         if (bus_a.done === 1'b1) begin
            if (done_j < 0) done_j = j;
            donecnt++;
         end
         if (osc_en_a === 1'b1) encnt++;
         step();
      end
   endtask

   task automatic test_reset();
      #2;
      total++; if (osc_en_a !== 1'b0) begin $display("FAIL rst_osc_en_a: got %b, expected 0", osc_en_a); end else passed++;
      total++; if (bus_a.busy !== 1'b0) begin $display("FAIL rst_busy_a: got %b, expected 0", bus_a.busy); end else passed++;
      total++; if (bus_a.done !== 1'b0) begin $display("FAIL rst_done_a: got %b, expected 0", bus_a.done); end else passed++;
      total++; if (bus_a.count !== 16'd0) begin $display("FAIL rst_count_a: got %0d, expected 0", bus_a.count); end else passed++;
      total++; if (bus_a.overflow !== 1'b0) begin $display("FAIL rst_ovf_a: got %b, expected 0", bus_a.overflow); end else passed++;
      total++; if (bus_b.count !== 4'd0 || osc_en_b !== 1'b0) begin
         $display("FAIL rst_b: got count=%0d osc_en=%b, expected 0/0", bus_b.count, osc_en_b); end else passed++;
      step(); step();
      rst_n = 1'b1;
      for (int i = 0; i < 20; i++) step();
      total++; if (bus_a.busy !== 1'b0 || osc_en_a !== 1'b0) begin
         $display("FAIL idle_after_rst: got busy=%b osc_en=%b, expected 0/0", bus_a.busy, osc_en_a); end else passed++;
   endtask

   task automatic test_basic();
      int dj, dc, ec;
      start_a(16'd100);
      run_a(160, dj, dc, ec);
      total++; if (dj !== 117) begin $display("FAIL basic_done_time: got %0d, expected 117", dj); end else passed++;
      total++; if (dc !== 1) begin $display("FAIL basic_done_count: got %0d, expected 1", dc); end else passed++;
      total++; if (ec !== 117) begin $display("FAIL basic_osc_en_cycles: got %0d, expected 117", ec); end else passed++;
      total++; if (!(bus_a.count >= 16'd9 && bus_a.count <= 16'd11)) begin
         $display("FAIL basic_count: got %0d, expected 9..11", bus_a.count); end else passed++;
      total++; if (bus_a.overflow !== 1'b0) begin $display("FAIL basic_ovf: got %b, expected 0", bus_a.overflow); end else passed++;
      total++; if (bus_a.busy !== 1'b0) begin $display("FAIL basic_busy_end: got %b, expected 0", bus_a.busy); end else passed++;
   endtask

   task automatic test_zero_window();
      int dj, dc, ec;
      start_a(16'd0);
      total++; if (bus_a.busy !== 1'b1 || bus_a.done !== 1'b0 || osc_en_a !== 1'b0) begin
         $display("FAIL zw_accept: got busy=%b done=%b osc_en=%b, expected 1/0/0", bus_a.busy, bus_a.done, osc_en_a); end else passed++;
      step();
      total++; if (bus_a.done !== 1'b1 || bus_a.busy !== 1'b0 || osc_en_a !== 1'b0) begin
         $display("FAIL zw_done: got done=%b busy=%b osc_en=%b, expected 1/0/0", bus_a.done, bus_a.busy, osc_en_a); end else passed++;
      total++; if (bus_a.count !== 16'd0 || bus_a.overflow !== 1'b0) begin
         $display("FAIL zw_result: got count=%0d ovf=%b, expected 0/0", bus_a.count, bus_a.overflow); end else passed++;
      step();
      run_a(10, dj, dc, ec);
      total++; if (dc !== 0 || ec !== 0) begin $display("FAIL zw_quiet: got done=%0d osc_en=%0d, expected 0/0", dc, ec); end else passed++;
   endtask

   task automatic test_abort();
      int dj, dc, ec;
      start_a(16'd70);
      run_a(120, dj, dc, ec);
      total++; if (dc !== 1 || bus_a.count !== 16'd7) begin
         $display("FAIL abort_pre_count: got dones=%0d count=%0d, expected 1/7", dc, bus_a.count); end else passed++;
      start_a(16'd100);
      for (int i = 0; i < 45; i++) step();
      bus_a.abort = 1'b1;
      step();
      bus_a.abort = 1'b0;
      total++; if (osc_en_a !== 1'b0 || bus_a.busy !== 1'b0) begin
         $display("FAIL abort_stop: got osc_en=%b busy=%b, expected 0/0", osc_en_a, bus_a.busy); end else passed++;
      run_a(150, dj, dc, ec);
      total++; if (dc !== 0) begin $display("FAIL abort_no_done: got %0d, expected 0", dc); end else passed++;
      total++; if (bus_a.count !== 16'd7 || bus_a.overflow !== 1'b0) begin
         $display("FAIL abort_hold: got count=%0d ovf=%b, expected 7/0", bus_a.count, bus_a.overflow); end else passed++;
      start_a(16'd50);
      run_a(100, dj, dc, ec);
      total++; if (dj !== 67 || bus_a.count !== 16'd5) begin
         $display("FAIL abort_rerun: got done_at=%0d count=%0d, expected 67/5", dj, bus_a.count); end else passed++;
   endtask

   task automatic test_back_to_back();
      int dj = -1;
      int dc = 0;
      int ec = 0;
      start_a(16'd100);
      for (int j = 0; j < 160; j++) begin
         if (bus_a.done === 1'b1) begin
            if (dj < 0) dj = j;
            dc++;
         end
         if (osc_en_a === 1'b1) ec++;
         bus_a.start  = (j == 5 || j == 50);
         bus_a.window = (j == 5) ? 16'd3 : 16'd0;
         step();
      end
      bus_a.start = 1'b0;
      total++; if (dj !== 117 || dc !== 1) begin
         $display("FAIL b2b_done: got at=%0d dones=%0d, expected 117/1", dj, dc); end else passed++;
      total++; if (ec !== 117) begin $display("FAIL b2b_osc_en_cycles: got %0d, expected 117", ec); end else passed++;
      total++; if (!(bus_a.count >= 16'd9 && bus_a.count <= 16'd11)) begin
         $display("FAIL b2b_count: got %0d, expected 9..11", bus_a.count); end else passed++;
   endtask

   task automatic test_saturate();
      for (int run = 0; run < 2; run++) begin
         int dj = -1;
         int dc = 0;
         osc_half = (run == 0) ? 2 : 10;
         for (int i = 0; i < 40; i++) step();
         bus_b.start  = 1'b1;
         bus_b.window = 16'd100;
         step();
         bus_b.start  = 1'b0;
         for (int j = 0; j < 200; j++) begin
            if (bus_b.done === 1'b1) begin
               if (dj < 0) dj = j;
               dc++;
            end
            step();
         end
         total++; if (dj !== 117 || dc !== 1) begin
            $display("FAIL sat_done_run%0d: got at=%0d dones=%0d, expected 117/1", run, dj, dc); end else passed++;
         if (run == 0) begin
            total++; if (bus_b.count !== 4'd15 || bus_b.overflow !== 1'b1) begin
               $display("FAIL sat_fast: got count=%0d ovf=%b, expected 15/1", bus_b.count, bus_b.overflow); end else passed++;
         end else begin
            total++; if (bus_b.count !== 4'd5 || bus_b.overflow !== 1'b0) begin
               $display("FAIL sat_slow: got count=%0d ovf=%b, expected 5/0", bus_b.count, bus_b.overflow); end else passed++;
         end
      end
      osc_half = 5;
      for (int i = 0; i < 40; i++) step();
   endtask

   task automatic test_reset_midrun();
      int dj, dc, ec;
      start_a(16'd100);
      for (int i = 0; i < 60; i++) step();
      #2;
      rst_n = 1'b0;
      #1;
      total++; if (osc_en_a !== 1'b0 || bus_a.busy !== 1'b0) begin
         $display("FAIL midrst_async: got osc_en=%b busy=%b, expected 0/0", osc_en_a, bus_a.busy); end else passed++;
      total++; if (bus_a.count !== 16'd0 || bus_a.overflow !== 1'b0 || bus_b.count !== 4'd0) begin
         $display("FAIL midrst_result: got count_a=%0d ovf_a=%b count_b=%0d, expected 0/0/0",
                  bus_a.count, bus_a.overflow, bus_b.count); end else passed++;
      #1;
      rst_n = 1'b1;
      for (int i = 0; i < 20; i++) step();
      total++; if (bus_a.busy !== 1'b0 || bus_a.done !== 1'b0) begin
         $display("FAIL midrst_idle: got busy=%b done=%b, expected 0/0", bus_a.busy, bus_a.done); end else passed++;
      start_a(16'd100);
      run_a(160, dj, dc, ec);
      total++; if (dj !== 117 || dc !== 1 || !(bus_a.count >= 16'd9 && bus_a.count <= 16'd11)) begin
         $display("FAIL midrst_rerun: got at=%0d dones=%0d count=%0d, expected 117/1/9..11", dj, dc, bus_a.count); end else passed++;
   endtask

   initial begin
      bus_a.start = 1'b0; bus_a.abort = 1'b0; bus_a.window = '0;
      bus_b.start = 1'b0; bus_b.abort = 1'b0; bus_b.window = '0;
      test_reset();
      test_basic();
      test_zero_window();
      test_abort();
      test_back_to_back();
      test_saturate();
      test_reset_midrun();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

// File: doc/osc_freq_counter.md
Name: osc_freq_counter

Overview:
- Measures the frequency of the gated ring-oscillator output, downstream of the oscillator macro.
- Drives the oscillator enable and lets it settle.
- Synchronises the asynchronous oscillator output into the system clock domain and counts its rising edges over a programmable window of system-clock cycles.
- Publishes the result with a one-cycle done strobe for readout logic.

Parameters:
- CNT_W, 16, width of the edge count result.
- WIN_W, 16, width of the measurement-window length input.
- SETTLE, 16, number of clk cycles the oscillator is enabled before counting starts (at least 1).

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request a measurement; sampled only in IDLE
- abort  input  1  cancel an in-progress measurement
- window  input  WIN_W  measurement length in clk cycles; latched on accepted start
- osc_in  input  1  oscillator output, asynchronous to clk
- osc_en  output  1  oscillator enable, registered
- busy  output  1  high from accepted start until return to IDLE
- done  output  1  one-cycle strobe when count/overflow are updated
- count  output  CNT_W  rising edges seen in last completed window
- overflow  output  1  last completed window saturated count

Behaviour:
- Interface: single clock clk; reset rst_n is asynchronous, active-low.
- Reset values: state IDLE, osc_en=0, busy=0, done=0, count=0, overflow=0. Synchroniser and edge flops are 0. Latched window and internal counters are 0.
- Synchroniser: two flops on osc_in (s1, s2), then history flop s3. rise = s2 & ~s3. All three flops run continuously regardless of state.
- Correct counting requires osc frequency < clk/2; faster inputs alias and this is not flagged.
- IDLE:
  - start=1 & abort=0 & window!=0: latch window, go SETTLE. osc_en=1 and busy=1 from next cycle.
  - start=1 & abort=0 & window==0: go DONE directly; osc_en stays 0.
  - start=1 & abort=1: ignored, remain IDLE.
- SETTLE:
  - Lasts exactly SETTLE cycles, then MEASURE.
  - Edge counter is cleared; rise is ignored.
- MEASURE:
  - Lasts exactly the latched window cycles.
  - Each cycle with rise=1 increments the edge counter.
  - At all-ones, the counter holds and a sticky sat flag is set.
- DONE:
  - Exactly one cycle: done=1.
  - count <= edge counter; overflow <= sat flag (both 0 for window==0 path).
  - osc_en=0 and busy=0 from the next cycle; return to IDLE.
- Latency: start sampled at edge k → done high in the cycle after edge k+1+SETTLE+window (window!=0), or after edge k+1 (window==0).
- count and overflow hold between done strobes.
- abort in SETTLE or MEASURE: next cycle IDLE, osc_en=0, busy=0, no done. count and overflow unchanged.
- abort in DONE: ignored; the done strobe completes.
- start while busy: ignored, no queuing.
- Changes to window while busy have no effect.
- rst_n low at any time: all state returns to reset values immediately (osc_en drops asynchronously).

Test Plan:
- SETTLE=16, window=100, osc_in square wave period 10 clk: done at start+118, count=10 (±1), overflow=0, osc_en high exactly 117 cycles.
- window=0, start pulse: done one cycle after acceptance, count=0, overflow=0, osc_en never asserted, busy high one cycle.
- CNT_W=4, window=100, osc period 4 clk: count=15, overflow=1. A following run with osc period 20 gives count=5, overflow=0.
- Abort at cycle 30 of MEASURE with previous count=7: no done, osc_en low next cycle, count stays 7. A new start then measures normally.
- Second start pulses during SETTLE and MEASURE: exactly one done; timing unchanged from single-start case.
- rst_n asserted mid-MEASURE: osc_en/busy/count/overflow go 0 without waiting for clk. After release, the block is in IDLE and a new start completes normally.
